timer_counter: RTL
==================

# timer_counter

Counting core of the 8-bit timer. It consumes the TDR value and the TCR control fields held by the APB register block and produces the live count TCNT. It also produces single-cycle overflow and underflow pulses, which the register block turns into sticky status bits. It contains the clock prescaler and the up/down counter and has no bus interface of its own.

## Interface
Parameters:
- `WIDTH`, 8: counter and TDR width.
- `DIV_W`, 4: prescaler counter width; must be at least the largest divide exponent.

Ports:
- `pclk` input, 1: system clock. Everything is sampled on the rising edge.
- `prst` input, 1: reset, asynchronous, active-high.
- `tdr` input, WIDTH: load value from the TDR register.
- `load` input, 1: TCR.load. While high, the counter is forced to `tdr`.
- `up_dn` input, 1: TCR.up_dn. 0 counts up, 1 counts down.
- `en` input, 1: TCR.en. Enables counting.
- `cks` input, 2: TCR.cks, the clock select. 00 = pclk/2, 01 = /4, 10 = /8, 11 = /16.
- `tcnt` output, WIDTH: current count, registered.
- `ovf` output, 1: one-cycle pulse on the up-count wrap FF→00.
- `udf` output, 1: one-cycle pulse on the down-count wrap 00→FF.

## Operation
- Reset values: `tcnt`=0, `ovf`=0, `udf`=0, `div_cnt`=0, `cks_q`=0.
- Prescaler:
  - `div_max` = 2^(cks+1) − 1.
  - When `en`=1, `load`=0 and `cks`==`cks_q`, `div_cnt` increments and wraps to 0 after reaching `div_max`.
  - `tick` = (`en` & !`load` & `div_cnt`==`div_max`). It is combinational and internal.
  - `div_cnt` clears to 0 when `en`=0, when `load`=1, or when `cks`≠`cks_q` (a clock-select change). `cks_q` is the copy of `cks` registered every cycle.
- Priority of counter updates, highest first:
  1. `load`=1: `tcnt`←`tdr` every cycle. No pulses are produced. The prescaler holds at 0.
  2. `tick`=1 and `up_dn`=0: `tcnt`←`tcnt`+1, modulo 2^WIDTH. `ovf`←1 when `tcnt`==all-ones, otherwise 0.
  3. `tick`=1 and `up_dn`=1: `tcnt`←`tcnt`−1, modulo 2^WIDTH. `udf`←1 when `tcnt`==0, otherwise 0.
  4. Otherwise `tcnt` holds and `ovf`=`udf`=0.
- `ovf` and `udf` are registered together with `tcnt`. Each is high for exactly one pclk, in the cycle where `tcnt` shows the wrapped value. They are never high at the same time.
- Changing `up_dn` mid-count takes effect at the next tick. The prescaler is not cleared.
- Changing `tdr` while `load`=0 has no effect on `tcnt`.
- `en`=0 freezes `tcnt` at its current value. Re-enabling resumes from that value with a fresh prescaler phase.

## Timing
- Tick period is 2^(cks+1) pclk cycles.
- First update after `en` is first sampled high at edge N, with `div_cnt`=0: `tcnt` changes at edge N+2^(cks+1)−1 and is visible the following cycle. Example: `cks`=00 gives an update at edge N+1.
- Load latency: `tdr` appears on `tcnt` one edge after `load` is sampled high.
- A clock-select change is sampled at edge M. `div_cnt` is 0 after M+1, and the new period starts from there. No tick fires in the change cycle.
- Asynchronous reset mid-count: all outputs go to 0 immediately. A pulse in flight is dropped.

## Structure
- Shared `timer_pkg` holds:
  - TCR bit positions: `LOAD_BIT`=7, `UPDN_BIT`=5, `EN_BIT`=4, `CKS_LSB`=0.
  - `cks` encodings `CKS_DIV2`..`CKS_DIV16`.
  - The TDR/TCR/TSR address constants 8'h00/8'h01/8'h02, which the register block also uses.
- One sub-module, `timer_prescaler`. Inputs: `pclk`, `prst`, `en`, `load`, `cks`. Output: `tick`. It owns `div_cnt` and `cks_q`.
- `timer_counter` instantiates `timer_prescaler` and owns `tcnt`, `ovf` and `udf`.

## Test plan
- Reset: assert `prst` mid-count with `tcnt`=8'h37 → `tcnt`=0, `ovf`=`udf`=0 immediately. They stay 0 after release while `en`=0.
- Overflow: `tdr`=8'hFD, `load` for 1 cycle, then `en`=1, `up_dn`=0, `cks`=00 → `tcnt` steps FE, FF, 00 every 2 pclk. `ovf` is high for exactly the one cycle `tcnt`=00.
- Underflow: `tdr`=8'h01, load, `up_dn`=1, `cks`=11 → `tcnt`=00 after 16 pclk and FF after 32. `udf` is a 1-cycle pulse with FF.
- Prescaler sweep: for `cks`=00..11 from `tcnt`=0, count 10 ticks → elapsed pclk is exactly 20/40/80/160.
- `cks` change from 11 to 00 mid-period with `div_cnt`=9 → no tick in that cycle. The next increment comes exactly 2 pclk after `div_cnt` clears.
- `load` held high with `en`=1 while `tdr` changes A5→5A → `tcnt` follows `tdr` with 1-cycle lag and no pulses. After release, the first increment comes a full tick period later.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared timer definitions: TCR field positions, clock-select encodings and
// the register addresses also used by the APB register block.
package timer_pkg;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned CKS_W    = 2;

  localparam int unsigned LOAD_BIT = 7;
  localparam int unsigned UPDN_BIT = 5;
  localparam int unsigned EN_BIT   = 4;
  localparam int unsigned CKS_LSB  = 0;

  typedef enum logic [CKS_W-1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  localparam logic [ADDR_W-1:0] ADDR_TDR = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_TCR = 8'h01;
  localparam logic [ADDR_W-1:0] ADDR_TSR = 8'h02;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a one-cycle tick every 2^(cks+1) pclk while enabled,
// restarting its phase on disable, load or any clock-select change.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             en,
  input  logic             load,
  input  logic [CKS_W-1:0] cks,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic [DIV_W-1:0] div_max;
  logic [CKS_W-1:0] cks_q;
  logic             run;

  always_comb begin
    div_max = DIV_W'(1);
    case (cks)
      CKS_DIV2:  div_max = DIV_W'(1);
      CKS_DIV4:  div_max = DIV_W'(3);
      CKS_DIV8:  div_max = DIV_W'(7);
      CKS_DIV16: div_max = DIV_W'(15);
      default:   div_max = DIV_W'(1);
    endcase
  end

  // A clock-select change suppresses the tick so the old phase never leaks
  // into the new period.
  always_comb begin
    run       = en & ~load & (cks == cks_q);
    tick      = run & (div_cnt_q == div_max);
    div_cnt_d = '0;
    if (run && (div_cnt_q != div_max)) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      div_cnt_q <= '0;
      cks_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      cks_q     <= cks;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Timer counting core: loadable up/down counter advanced by the prescaler tick,
// with registered single-cycle overflow/underflow pulses.
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic [WIDTH-1:0] tdr,
  input  logic             load,
  input  logic             up_dn,
  input  logic             en,
  input  logic [CKS_W-1:0] cks,
  output logic [WIDTH-1:0] tcnt,
  output logic             ovf,
  output logic             udf
);

  logic             tick;
  logic [WIDTH-1:0] tcnt_q;
  logic [WIDTH-1:0] tcnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             udf_q;
  logic             udf_d;

  timer_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .pclk(pclk),
    .prst(prst),
    .en  (en),
    .load(load),
    .cks (cks),
    .tick(tick)
  );

  // Load wins over counting; pulses flag the wrap in the same cycle it shows.
  always_comb begin
    tcnt_d = tcnt_q;
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
    if (load) begin
      tcnt_d = tdr;
    end else if (tick) begin
      if (!up_dn) begin
        tcnt_d = tcnt_q + WIDTH'(1);
        ovf_d  = (tcnt_q == '1);
      end else begin
        tcnt_d = tcnt_q - WIDTH'(1);
        udf_d  = (tcnt_q == '0);
      end
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      tcnt_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign tcnt = tcnt_q;
  assign ovf  = ovf_q;
  assign udf  = udf_q;

endmodule
